// File: rtl/alu_exec.sv
// Execute stage: single-cycle logic/add/sub ops and an iterative shift-add multiply.
// Results and flags are registered and held until the next completed operation.
module alu_exec #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] DA,
    input  logic [DW-1:0] DB,
    output logic [DW-1:0] Y,
    output logic [DW-1:0] YH,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_n,
    output logic          flag_v,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(DW + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    state_t          state, nstate;
    flags_t          flg, alu_f, mul_f;
    logic [DW-1:0]   alu_y;
    logic [DW:0]     sum;
    logic [DW-1:0]   mcand, mplier;
    logic [2*DW-1:0] acc, acc_nxt;
    logic [CW-1:0]   cnt;
    logic            last;

    // Single-cycle datapath; sum carries one extra bit for carry/borrow.
    always_comb begin
        sum   = '0;
        alu_y = '0;
        alu_f = '0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, DA} + {1'b0, DB};
                alu_y   = sum[DW-1:0];
                alu_f.c = sum[DW];
                alu_f.v = (DA[DW-1] == DB[DW-1]) && (alu_y[DW-1] != DA[DW-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, DA} - {1'b0, DB};
                alu_y   = sum[DW-1:0];
                alu_f.c = sum[DW];
                alu_f.v = (DA[DW-1] != DB[DW-1]) && (alu_y[DW-1] != DA[DW-1]);
            end
            OP_AND:  alu_y = DA & DB;
            OP_OR:   alu_y = DA | DB;
            OP_XOR:  alu_y = DA ^ DB;
            OP_NOT:  alu_y = ~DA;
            OP_MOV:  alu_y = DB;
            default: alu_y = '0;
        endcase
        alu_f.z = (alu_y == '0);
        alu_f.n = alu_y[DW-1];
    end

    // One shift-add iteration per cycle; last marks the DW-th iteration.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? ({{DW{1'b0}}, mcand} << cnt) : '0);
        last    = (cnt == CW'(DW - 1));
        mul_f.z = (acc_nxt == '0);
        mul_f.c = (acc_nxt[2*DW-1:DW] != '0);
        mul_f.n = acc_nxt[DW-1];
        mul_f.v = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start && op == OP_MUL) nstate = MUL;
            MUL:     if (last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y      <= '0;
            YH     <= '0;
            flg    <= '0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand  <= DA;
                            mplier <= DB;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            Y    <= alu_y;
                            YH   <= '0;
                            flg  <= alu_f;
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        {YH, Y} <= acc_nxt;
                        flg     <= mul_f;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // busy follows the state register so reset drops it asynchronously.
    assign busy   = (state == MUL);
    assign flag_z = flg.z;
    assign flag_c = flg.c;
    assign flag_n = flg.n;
    assign flag_v = flg.v;
endmodule
